cordic_word_seq: RTL

Iteration sequencer for the word-serial CORDIC engine. It accepts one operand handshake and loads the datapath registers. It then steps the arctan LUT address and iteration enable through the programmed number of micro-rotations. It optionally schedules the reciprocal-gain multiply, then presents the result with valid/ready backpressure. It sits between the CoreCORDIC top-level handshake and the word-serial shift/add datapath plus its constant-angle ROM.

---
 rtl/cordic_word_pkg.sv | 42 ++++
 rtl/cordic_iter_cnt.sv | 48 ++++
 rtl/cordic_word_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cordic_word_pkg.sv
// ---------------------------------------------------------------------------
// cordic_word_pkg
// Shared definitions for the word-serial CORDIC iteration sequencer:
//   - default sizing (LUT address width, deepest LUT, gain-multiplier latency)
//   - sequencer state enum
//   - helpers that validate and clamp the programmed iteration count
// Build macro: CORDIC_GAIN_COMP_EN adds the GAIN state to the enum.
// ---------------------------------------------------------------------------
package cordic_word_pkg;

  localparam int DEF_LOGITER  = 6;
  localparam int DEF_MAX_ITER = 48;
  localparam int DEF_GAIN_LAT = 2;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_GAIN,
    ST_DONE
  } seq_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_DONE
  } seq_state_e;
`endif

  // An iteration count of zero or one deeper than the angle LUT is unusable.
  function automatic bit iter_illegal(input int n, input int max_iter);
    return (n < 1) || (n > max_iter);
  endfunction

  // Unusable counts fall back to the full LUT depth.
  function automatic int clamp_iter(input int n, input int max_iter);
    return iter_illegal(n, max_iter) ? max_iter : n;
  endfunction

endpackage

// File: rtl/cordic_iter_cnt.sv
// ---------------------------------------------------------------------------
// cordic_iter_cnt
// Loadable up-counter producing the arctan LUT address / shift amount.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   clken       global clock enable; low freezes the counter
//   load        clear the count and capture the iteration total n_in
//   step        a micro-rotation is being performed this cycle
//   n_in        iteration total (already clamped to 1..MAX_ITER)
//   cnt         current LUT address, 0 .. n-1
//   done        this enabled step is the final micro-rotation
// ---------------------------------------------------------------------------
module cordic_iter_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clken,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] n_in,
  output logic [W-1:0] cnt,
  output logic         done
);

  logic [W-1:0] n_q;
  logic         last;

  // The count saturates at n-1 so the shift amount stays valid while the
  // gain pipeline and result handshake are still using the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      n_q <= W'(1);
    end else if (clken) begin
      if (load) begin
        cnt <= '0;
        n_q <= n_in;
      end else if (step && !last) begin
        cnt <= cnt + W'(1);
      end
    end
  end

  assign last = (cnt == (n_q - W'(1)));
  assign done = clken && step && last;

endmodule

// File: rtl/cordic_word_seq.sv
// ---------------------------------------------------------------------------
// cordic_word_seq
// Iteration sequencer for the word-serial CORDIC engine. Accepts one operand,
// strobes the datapath load, steps the LUT address through n micro-rotations,
// optionally runs the reciprocal-gain multiply, then holds the result valid
// until the downstream handshake completes.
// Build macro: CORDIC_GAIN_COMP_EN enables the GAIN state; when undefined
// GAIN_EN is tied low and ITER goes straight to DONE.
// Ports:
//   CLK, RST    rising-edge clock, synchronous active-high reset (beats CLKEN)
//   CLKEN       global clock enable; low freezes state and outputs
//   DIN_VALID   operand offered;  RDY  sequencer can take it this cycle
//   N_ITER      iteration count, sampled on accept
//   LOAD        datapath input-register load strobe
//   ITER_EN     micro-rotation enable; ITER_CNT  LUT address / shift amount
//   GAIN_EN     gain-multiplier pipeline enable
//   DOUT_VALID  result valid; DOUT_READY  downstream accepts result
//   CFG_ERR     pulse in the LOAD cycle when N_ITER was clamped
// ---------------------------------------------------------------------------
module cordic_word_seq
  import cordic_word_pkg::*;
#(
  parameter int LOGITER  = DEF_LOGITER,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int GAIN_LAT = DEF_GAIN_LAT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLKEN,
  input  logic               DIN_VALID,
  output logic               RDY,
  input  logic [LOGITER-1:0] N_ITER,
  output logic               LOAD,
  output logic               ITER_EN,
  output logic [LOGITER-1:0] ITER_CNT,
  output logic               GAIN_EN,
  output logic               DOUT_VALID,
  input  logic               DOUT_READY,
  output logic               CFG_ERR
);

  if (GAIN_LAT < 1 || MAX_ITER < 1 || MAX_ITER >= (1 << LOGITER)) begin : g_cfg_check
    $error("cordic_word_seq: illegal LOGITER/MAX_ITER/GAIN_LAT combination");
  end

  seq_state_e         state_q;
  seq_state_e         state_d;
  logic               accept;
  logic               iter_step;
  logic               iter_done;
  logic               err_q;
  logic [LOGITER-1:0] n_load;

  // RDY already folds in DOUT_READY while in DONE, so this one term covers
  // both the idle accept and the back-to-back accept.
  assign accept    = RDY && DIN_VALID && CLKEN;
  assign iter_step = (state_q == ST_ITER);
  assign n_load    = LOGITER'(clamp_iter(int'(N_ITER), MAX_ITER));

  cordic_iter_cnt #(
    .W(LOGITER)
  ) u_iter_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clken (CLKEN),
    .load  (accept),
    .step  (iter_step),
    .n_in  (n_load),
    .cnt   (ITER_CNT),
    .done  (iter_done)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam int GW = (GAIN_LAT > 1) ? $clog2(GAIN_LAT) : 1;

  logic [GW-1:0] gain_cnt;
  logic          gain_last;

  // Counts cycles spent in GAIN; cleared everywhere else so each result
  // gets the full multiplier latency.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gain_cnt <= '0;
    end else if (CLKEN) begin
      if (state_q == ST_GAIN) begin
        gain_cnt <= gain_cnt + GW'(1);
      end else begin
        gain_cnt <= '0;
      end
    end
  end

  assign gain_last = (gain_cnt == GW'(GAIN_LAT - 1));
`endif

  // State register; the clamp flag is captured on accept and only shown
  // during the LOAD cycle that follows.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else if (CLKEN) begin
      state_q <= state_d;
      if (accept) begin
        err_q <= iter_illegal(int'(N_ITER), MAX_ITER);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (DIN_VALID) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (iter_done) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_GAIN;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_GAIN: begin
        if (gain_last) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (DOUT_READY) begin
          state_d = DIN_VALID ? ST_LOAD : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of the registered state; the only
  // combinational input path is RDY following DOUT_READY in DONE.
  always_comb begin
    RDY        = 1'b0;
    LOAD       = 1'b0;
    ITER_EN    = 1'b0;
    GAIN_EN    = 1'b0;
    DOUT_VALID = 1'b0;
    CFG_ERR    = 1'b0;
    case (state_q)
      ST_IDLE: RDY = 1'b1;
      ST_LOAD: begin
        LOAD    = 1'b1;
        CFG_ERR = err_q;
      end
      ST_ITER: ITER_EN = 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
      ST_GAIN: GAIN_EN = 1'b1;
`endif
      ST_DONE: begin
        DOUT_VALID = 1'b1;
        RDY        = DOUT_READY;
      end
      default: ;
    endcase
  end

endmodule
